// File: rtl/ascensor_pkg.sv
// ascensor_pkg: shared types and constants for the four-floor elevator controller.
//   - ACC_*      : codes driven on the 'accion' output
//   - PUERTA_*   : codes driven on the 'puertas' output
//   - estado_t   : controller state (IDLE / MOVING / DOORS)
//   - dir_t      : scan direction remembered between stops
//   - mascara_arriba / mascara_abajo : floor masks strictly above / below a floor
package ascensor_pkg;

   localparam logic [1:0] ACC_PARADO = 2'd0;
   localparam logic [1:0] ACC_SUBE   = 2'd1;
   localparam logic [1:0] ACC_BAJA   = 2'd2;

   localparam logic PUERTA_CERRADA = 1'b0;
   localparam logic PUERTA_ABIERTA = 1'b1;

   typedef enum logic [1:0] {IDLE, MOVING, DOORS} estado_t;
   typedef enum logic {DIR_SUBE, DIR_BAJA} dir_t;

   // Bits with index > f.
   function automatic logic [3:0] mascara_arriba(input logic [1:0] f);
      mascara_arriba = 4'b1110 << f;
   endfunction

   // Bits with index < f.
   function automatic logic [3:0] mascara_abajo(input logic [1:0] f);
      mascara_abajo = (4'b0001 << f) - 4'd1;
   endfunction

endpackage

// File: rtl/ascensor_timer.sv
// ascensor_timer: loadable down-counter shared by travel and door timing.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load 'value' into the counter this cycle
//   value      : count to load (number of cycles until 'expired')
//   expired    : high during the last counted cycle (count == 1)
// A load of N makes 'expired' rise exactly N cycles later (N >= 1).
module ascensor_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         expired
);

   logic [W-1:0] cuenta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cuenta <= '0;
      end else if (load) begin
         cuenta <= value;
      end else if (cuenta != '0) begin
         cuenta <= cuenta - W'(1);
      end
   end

   assign expired = (cuenta == W'(1));

endmodule

// File: rtl/ascensor_control.sv
// ascensor_control: collective up/down scan controller for a four-floor elevator.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req[3:0]    : level-sensitive call buttons, one per floor
//   obstruccion : door sensor; holds the doors open only when OBSTRUCCION_EN is defined
//   piso        : current floor 0..3
//   accion      : ACC_PARADO / ACC_SUBE / ACC_BAJA
//   puertas     : PUERTA_CERRADA / PUERTA_ABIERTA
//   pendientes  : latched pending calls (button lamps)
// Parameters: TRAVEL_CYCLES cycles per floor, DOOR_CYCLES cycles with doors open.
// Optional feature macro: OBSTRUCCION_EN.
module ascensor_control
   import ascensor_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 50_000_000,
   parameter int DOOR_CYCLES   = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       obstruccion,
   output logic [1:0] piso,
   output logic [1:0] accion,
   output logic       puertas,
   output logic [3:0] pendientes
);

   localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);
   localparam logic [TW-1:0] T_VIAJE  = TW'(TRAVEL_CYCLES);
   localparam logic [TW-1:0] T_PUERTA = TW'(DOOR_CYCLES);

   estado_t       estado, estado_n;
   dir_t          dir, dir_n;
   logic [1:0]    piso_n, accion_n, piso_sig;
   logic          puertas_n;
   logic [3:0]    pend_n, llamadas, sel_piso, sel_sig;
   logic          arriba, abajo, obst_act;
   logic          carga, expirado;
   logic [TW-1:0] carga_val;

`ifdef OBSTRUCCION_EN
   assign obst_act = obstruccion;
`else
   // Port kept so the instantiation is identical in both builds; it has no effect here.
   assign obst_act = obstruccion & 1'b0;
`endif

   // Travel and door timing never overlap, so one counter serves both.
   ascensor_timer #(.W(TW)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (carga),
      .value   (carga_val),
      .expired (expirado)
   );

   assign sel_piso = 4'b0001 << piso;
   assign piso_sig = (dir == DIR_SUBE) ? piso + 2'd1 : piso - 2'd1;
   assign sel_sig  = 4'b0001 << piso_sig;
   // Calls elsewhere, including buttons pressed this very cycle.
   assign llamadas = (pendientes | req) & ~sel_piso;
   assign arriba   = |(llamadas & mascara_arriba(piso));
   assign abajo    = |(llamadas & mascara_abajo(piso));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= IDLE;
         dir        <= DIR_SUBE;
         piso       <= 2'd0;
         accion     <= ACC_PARADO;
         puertas    <= PUERTA_CERRADA;
         pendientes <= 4'd0;
      end else begin
         estado     <= estado_n;
         dir        <= dir_n;
         piso       <= piso_n;
         accion     <= accion_n;
         puertas    <= puertas_n;
         pendientes <= pend_n;
      end
   end

   always_comb begin
      estado_n  = estado;
      dir_n     = dir;
      piso_n    = piso;
      accion_n  = accion;
      puertas_n = puertas;
      carga     = 1'b0;
      carga_val = T_VIAJE;
      pend_n    = pendientes | req;
      // While standing at a floor, its own button acts on the doors instead of latching.
      if (estado != MOVING) pend_n = pend_n & ~sel_piso;

      case (estado)
         IDLE: begin
            if (req[piso]) begin
               estado_n  = DOORS;
               puertas_n = PUERTA_ABIERTA;
               carga     = 1'b1;
               carga_val = T_PUERTA;
            end else if (arriba || abajo) begin
               estado_n = MOVING;
               carga    = 1'b1;
               if (arriba && (dir == DIR_SUBE || !abajo)) begin
                  dir_n    = DIR_SUBE;
                  accion_n = ACC_SUBE;
               end else begin
                  dir_n    = DIR_BAJA;
                  accion_n = ACC_BAJA;
               end
            end
         end
         MOVING: begin
            if (expirado) begin
               piso_n = piso_sig;
               carga  = 1'b1;
               // pend_n already includes a call made at the arrival floor this cycle.
               if (|(pend_n & sel_sig)) begin
                  pend_n    = pend_n & ~sel_sig;
                  estado_n  = DOORS;
                  accion_n  = ACC_PARADO;
                  puertas_n = PUERTA_ABIERTA;
                  carga_val = T_PUERTA;
               end
            end
         end
         DOORS: begin
            if (req[piso] || obst_act) begin
               carga     = 1'b1;
               carga_val = T_PUERTA;
            end else if (expirado) begin
               puertas_n = PUERTA_CERRADA;
               if ((dir == DIR_SUBE) ? arriba : abajo) begin
                  estado_n = MOVING;
                  accion_n = (dir == DIR_SUBE) ? ACC_SUBE : ACC_BAJA;
                  carga    = 1'b1;
               end else if ((dir == DIR_SUBE) ? abajo : arriba) begin
                  estado_n = MOVING;
                  dir_n    = (dir == DIR_SUBE) ? DIR_BAJA : DIR_SUBE;
                  accion_n = (dir == DIR_SUBE) ? ACC_BAJA : ACC_SUBE;
                  carga    = 1'b1;
               end else begin
                  estado_n = IDLE;
               end
            end
         end
         default: estado_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ascensor_control.sv
// tb_ascensor_control: directed self-checking bench for ascensor_control
// with TRAVEL_CYCLES = 4 and DOOR_CYCLES = 3. Compile with +define+OBSTRUCCION_EN
// to exercise the obstruction feature; expectations follow the macro.
module tb_ascensor_control;
   import ascensor_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       obstruccion;
   logic [1:0] piso;
   logic [1:0] accion;
   logic       puertas;
   logic [3:0] pendientes;

   int n_chk  = 0;
   int n_fail = 0;

   ascensor_control #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .obstruccion (obstruccion),
      .piso        (piso),
      .accion      (accion),
      .puertas     (puertas),
      .pendientes  (pendientes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 4'd0;
      obstruccion = 1'b0;
      tick_n(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = 4'd0;
      obstruccion = 1'b0;
      tick_n(2);
      n_chk++; if (piso !== 2'd0) begin n_fail++; $display("FAIL reset_piso: got %0d expected 0", piso); end
      n_chk++; if (accion !== 2'd0) begin n_fail++; $display("FAIL reset_accion: got %0d expected 0", accion); end
      n_chk++; if (puertas !== 1'b0) begin n_fail++; $display("FAIL reset_puertas: got %0d expected 0", puertas); end
      n_chk++; if (pendientes !== 4'd0) begin n_fail++; $display("FAIL reset_pend: got %b expected 0000", pendientes); end
      n_chk++; if (dut.estado !== IDLE) begin n_fail++; $display("FAIL reset_estado: got %0d expected IDLE", dut.estado); end
      n_chk++; if (dut.dir !== DIR_SUBE) begin n_fail++; $display("FAIL reset_dir: got %0d expected up", dut.dir); end
      rst_n = 1'b1;
      tick();
      n_chk++; if (accion !== 2'd0) begin n_fail++; $display("FAIL reset_idle_accion: got %0d expected 0", accion); end
   endtask

   task automatic test_subida();
      do_reset();
      req = 4'b1000;
      tick();
      req = 4'd0;
      for (int i = 0; i < 12; i++) begin
         n_chk++; if (accion !== ACC_SUBE) begin n_fail++; $display("FAIL up_accion[%0d]: got %0d expected 1", i, accion); end
         n_chk++; if (piso !== 2'(i / 4)) begin n_fail++; $display("FAIL up_piso[%0d]: got %0d expected %0d", i, piso, i / 4); end
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (puertas !== 1'b1) begin n_fail++; $display("FAIL up_puertas[%0d]: got %0d expected 1", i, puertas); end
         n_chk++; if (piso !== 2'd3 || accion !== 2'd0) begin n_fail++; $display("FAIL up_stop[%0d]: got piso %0d accion %0d expected 3 0", i, piso, accion); end
         n_chk++; if (pendientes !== 4'd0) begin n_fail++; $display("FAIL up_pend[%0d]: got %b expected 0000", i, pendientes); end
         tick();
      end
      n_chk++; if (puertas !== 1'b0) begin n_fail++; $display("FAIL up_close: got %0d expected 0", puertas); end
      tick_n(2);
      n_chk++; if (dut.estado !== IDLE || accion !== 2'd0) begin n_fail++; $display("FAIL up_idle: got estado %0d accion %0d expected IDLE 0", dut.estado, accion); end
   endtask

   task automatic test_puerta_local();
      do_reset();
      req = 4'b0001;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_chk++; if (puertas !== 1'b1) begin n_fail++; $display("FAIL local_hold[%0d]: got %0d expected 1", i, puertas); end
         n_chk++; if (pendientes !== 4'd0 || accion !== 2'd0) begin n_fail++; $display("FAIL local_pend[%0d]: got pend %b accion %0d expected 0000 0", i, pendientes, accion); end
      end
      req = 4'd0;
      for (int i = 0; i < 3; i++) begin
         n_chk++; if (puertas !== 1'b1) begin n_fail++; $display("FAIL local_tail[%0d]: got %0d expected 1", i, puertas); end
         tick();
      end
      n_chk++; if (puertas !== 1'b0) begin n_fail++; $display("FAIL local_close: got %0d expected 0", puertas); end
   endtask

   task automatic test_parada_intermedia();
      do_reset();
      req = 4'b1000;
      tick();                                   // t+1
      req = 4'd0;
      tick();                                   // t+2
      req = 4'b0010;
      tick();                                   // t+3
      req = 4'd0;
      n_chk++; if (pendientes !== 4'b1010) begin n_fail++; $display("FAIL mid_latch: got %b expected 1010", pendientes); end
      tick_n(2);                                // t+5
      n_chk++; if (piso !== 2'd1 || puertas !== 1'b1 || accion !== 2'd0) begin n_fail++; $display("FAIL mid_stop1: got piso %0d puertas %0d accion %0d expected 1 1 0", piso, puertas, accion); end
      n_chk++; if (pendientes !== 4'b1000) begin n_fail++; $display("FAIL mid_clear1: got %b expected 1000", pendientes); end
      tick_n(2);                                // t+7
      n_chk++; if (puertas !== 1'b1) begin n_fail++; $display("FAIL mid_open3: got %0d expected 1", puertas); end
      tick();                                   // t+8
      n_chk++; if (puertas !== 1'b0 || accion !== ACC_SUBE) begin n_fail++; $display("FAIL mid_resume: got puertas %0d accion %0d expected 0 1", puertas, accion); end
      tick_n(4);                                // t+12
      n_chk++; if (piso !== 2'd2 || accion !== ACC_SUBE || puertas !== 1'b0) begin n_fail++; $display("FAIL mid_pass2: got piso %0d accion %0d puertas %0d expected 2 1 0", piso, accion, puertas); end
      tick_n(4);                                // t+16
      n_chk++; if (piso !== 2'd3 || puertas !== 1'b1 || pendientes !== 4'd0) begin n_fail++; $display("FAIL mid_stop3: got piso %0d puertas %0d pend %b expected 3 1 0000", piso, puertas, pendientes); end
   endtask

   task automatic test_orden_servicio();
      do_reset();
      req = 4'b0100;
      tick();                                   // t+1
      req = 4'd0;
      tick_n(8);                                // t+9
      n_chk++; if (piso !== 2'd2 || puertas !== 1'b1) begin n_fail++; $display("FAIL order_at2: got piso %0d puertas %0d expected 2 1", piso, puertas); end
      req = 4'b1001;
      tick();                                   // t+10
      req = 4'd0;
      n_chk++; if (pendientes !== 4'b1001) begin n_fail++; $display("FAIL order_latch: got %b expected 1001", pendientes); end
      tick_n(2);                                // t+12
      n_chk++; if (accion !== ACC_SUBE || puertas !== 1'b0) begin n_fail++; $display("FAIL order_up: got accion %0d puertas %0d expected 1 0", accion, puertas); end
      tick_n(4);                                // t+16
      n_chk++; if (piso !== 2'd3 || accion !== 2'd0 || pendientes !== 4'b0001) begin n_fail++; $display("FAIL order_at3: got piso %0d accion %0d pend %b expected 3 0 0001", piso, accion, pendientes); end
      tick_n(3);                                // t+19
      n_chk++; if (accion !== ACC_BAJA || puertas !== 1'b0) begin n_fail++; $display("FAIL order_down: got accion %0d puertas %0d expected 2 0", accion, puertas); end
      tick_n(8);                                // t+27
      n_chk++; if (piso !== 2'd1 || accion !== ACC_BAJA) begin n_fail++; $display("FAIL order_pass1: got piso %0d accion %0d expected 1 2", piso, accion); end
      tick_n(4);                                // t+31
      n_chk++; if (piso !== 2'd0 || accion !== 2'd0 || puertas !== 1'b1 || pendientes !== 4'd0) begin n_fail++; $display("FAIL order_at0: got piso %0d accion %0d puertas %0d pend %b expected 0 0 1 0000", piso, accion, puertas, pendientes); end
   endtask

   task automatic test_reset_en_marcha();
      do_reset();
      req = 4'b1000;
      tick();                                   // t+1
      req = 4'd0;
      tick_n(5);                                // t+6, between floors 1 and 2
      n_chk++; if (piso !== 2'd1 || accion !== ACC_SUBE) begin n_fail++; $display("FAIL arst_pre: got piso %0d accion %0d expected 1 1", piso, accion); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (piso !== 2'd0 || accion !== 2'd0) begin n_fail++; $display("FAIL arst_now: got piso %0d accion %0d expected 0 0", piso, accion); end
      n_chk++; if (puertas !== 1'b0 || pendientes !== 4'd0) begin n_fail++; $display("FAIL arst_now2: got puertas %0d pend %b expected 0 0000", puertas, pendientes); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_obstruccion();
      int lim;
`ifdef OBSTRUCCION_EN
      lim = 13;
`else
      lim = 3;
`endif
      do_reset();
      req = 4'b0001;
      tick();                                   // t+1
      req = 4'd0;
      for (int k = 1; k <= 14; k++) begin
         obstruccion = (k <= 10);
         n_chk++; if (puertas !== 1'(k <= lim)) begin n_fail++; $display("FAIL obst[%0d]: got %0d expected %0d", k, puertas, (k <= lim)); end
         tick();
      end
      obstruccion = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      req = 4'd0;
      obstruccion = 1'b0;
      test_reset();
      test_subida();
      test_puerta_local();
      test_parada_intermedia();
      test_orden_servicio();
      test_reset_en_marcha();
      test_obstruccion();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
